// File: rtl/pmp_pkg.sv
// Shared types and default sizing for the PMM request dispatcher.
package pmp_pkg;
  localparam int DEF_NUM_MODULES = 4;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_CTRL_W      = 16;
  localparam int DEST_W          = $clog2(DEF_NUM_MODULES);

  typedef enum logic [1:0] {IDLE, PRESENT, DRAIN} slot_state_t;

  typedef struct packed {
    logic [DEST_W-1:0]     dest;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CTRL_W-1:0] control;
  } pmp_req_t;
endpackage

// File: rtl/pmp_req_fifo.sv
// In-order request FIFO; power-of-two depth so pointers wrap naturally.
module pmp_req_fifo import pmp_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  pmp_req_t      wdata,
  input  logic          pop,
  output pmp_req_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  pmp_req_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/pmp_dispatcher.sv
// Buffers host requests and presents them in order to per-slot PMM handshakes;
// also keeps sticky per-slot match flags.
module pmp_dispatcher import pmp_pkg::*; #(
  parameter int NUM_MODULES = DEF_NUM_MODULES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CTRL_W      = DEF_CTRL_W,
  parameter int FIFO_DEPTH  = 4,
  localparam int DW         = $clog2(NUM_MODULES)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DW-1:0]                       in_dest,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic [CTRL_W-1:0]                   in_control,
  output logic [NUM_MODULES-1:0][DATA_W-1:0]  data,
  output logic [NUM_MODULES-1:0][CTRL_W-1:0]  control,
  output logic [NUM_MODULES-1:0]              data_ready,
  input  logic [NUM_MODULES-1:0]              data_accepted,
  input  logic [NUM_MODULES-1:0]              pattern_accepted,
  input  logic [NUM_MODULES-1:0]              status_clear,
  output logic [NUM_MODULES-1:0]              match_status,
  output logic                                dest_err,
  output logic                                busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pmp_req_t   req_in, head;
  logic       fifo_full, fifo_empty, push, pop, dest_bad;
  logic [CW-1:0] fifo_count, count_nxt;

  slot_state_t [NUM_MODULES-1:0]             state_q, state_d;
  logic [NUM_MODULES-1:0]                    rdy_q, rdy_d, match_q, match_d;
  logic [NUM_MODULES-1:0][DATA_W-1:0]        data_q, data_d;
  logic [NUM_MODULES-1:0][CTRL_W-1:0]        ctrl_q, ctrl_d;
  logic                                      in_ready_q, in_ready_d, dest_err_q, dest_err_d;

  pmp_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (req_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    req_in     = '{dest: in_dest, data: in_data, control: in_control};
    dest_bad   = 32'(in_dest) >= NUM_MODULES;
    push       = in_valid & in_ready_q & ~dest_bad & ~fifo_full;
    dest_err_d = dest_err_q | (in_valid & in_ready_q & dest_bad);
    match_d    = (match_q & ~status_clear) | pattern_accepted;

    // In-order dispatch: only the head may leave, and only into an idle slot.
    pop = 1'b0;
    for (int j = 0; j < NUM_MODULES; j++)
      if (!fifo_empty && head.dest == DEST_W'(j) && state_q[j] == IDLE) pop = 1'b1;

    count_nxt  = fifo_count + CW'(push) - CW'(pop);
    in_ready_d = count_nxt < CW'(FIFO_DEPTH);

    state_d = state_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    busy    = ~fifo_empty;
    for (int j = 0; j < NUM_MODULES; j++) begin
      if (state_q[j] != IDLE) busy = 1'b1;
      case (state_q[j])
        IDLE: if (pop && head.dest == DEST_W'(j)) begin
          state_d[j] = PRESENT;
          rdy_d[j]   = 1'b1;
          data_d[j]  = head.data;
          ctrl_d[j]  = head.control;
        end
        PRESENT: if (data_accepted[j]) begin
          state_d[j] = DRAIN;
          rdy_d[j]   = 1'b0;
        end
        // Wait out the wrapper's registered acceptance level before reuse.
        DRAIN: if (!data_accepted[j]) state_d[j] = IDLE;
        default: begin
          state_d[j] = IDLE;
          rdy_d[j]   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= {NUM_MODULES{IDLE}};
      rdy_q      <= '0;
      data_q     <= '0;
      ctrl_q     <= '0;
      match_q    <= '0;
      in_ready_q <= 1'b1;
      dest_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      in_ready_q <= in_ready_d;
      dest_err_q <= dest_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign data         = data_q;
  assign control      = ctrl_q;
  assign data_ready   = rdy_q;
  assign match_status = match_q;
  assign dest_err     = dest_err_q;
endmodule
